// File: rtl/md5_msg_sched_if.sv
// Bundle of the byte-input, compression-core and digest-output signals of md5_msg_sched.
// master = scheduler side, slave = producer/core/consumer side.
interface md5_msg_sched_if;
    // Byte handshake: a byte moves on a rising clk edge where in_valid && in_ready.
    // The producer holds in_data/in_last stable while in_valid=1 and in_ready=0.
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;

    logic         core_start;
    logic [511:0] core_block;
    logic [31:0]  core_a;
    logic [31:0]  core_b;
    logic [31:0]  core_c;
    logic [31:0]  core_d;
    logic         core_done;
    logic [31:0]  core_ra;
    logic [31:0]  core_rb;
    logic [31:0]  core_rc;
    logic [31:0]  core_rd;

    logic [127:0] digest;
    logic         digest_valid;
    logic [7:0]   hex_data;
    logic         hex_wren;

    modport master (
        input  in_valid, in_data, in_last, core_done, core_ra, core_rb, core_rc, core_rd,
        output in_ready, core_start, core_block, core_a, core_b, core_c, core_d,
               digest, digest_valid, hex_data, hex_wren
    );

    modport slave (
        output in_valid, in_data, in_last, core_done, core_ra, core_rb, core_rc, core_rd,
        input  in_ready, core_start, core_block, core_a, core_b, core_c, core_d,
               digest, digest_valid, hex_data, hex_wren
    );
endinterface

// File: rtl/md5_msg_sched.sv
// MD5 message scheduler: packs bytes into padded 512-bit blocks, sequences the core, accumulates A..D.
// Optional ASCII-hex digest stream enabled by defining MD5_HEXOUT_EN.
module md5_msg_sched #(
    parameter logic [31:0] IV_A = 32'h67452301,
    parameter logic [31:0] IV_B = 32'hEFCDAB89,
    parameter logic [31:0] IV_C = 32'h98BADCFE,
    parameter logic [31:0] IV_D = 32'h10325476
) (
    input  logic            clk,
    input  logic            reset,
    md5_msg_sched_if.master bus,
    output logic [2:0]      state_dbg
);
    typedef enum logic [2:0] {
        ST_FILL   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_PADBLK = 3'd3,
        ST_FINAL  = 3'd4
`ifdef MD5_HEXOUT_EN
        , ST_HEX  = 3'd5
`endif
    } state_t;

    state_t        state, state_next;
    logic [5:0]    byte_cnt;
    logic [60:0]   msg_len;
    logic [31:0]   cha, chb, chc, chd;
    logic [511:0]  block;
    logic [127:0]  digest_r;
    logic          fin;
    logic          pad_pend;
    logic          pad80;
    logic          accept;
    logic          in_ready;
    logic          core_start;
    logic          digest_valid;
    logic [5:0]    slot_nxt;

    assign slot_nxt = byte_cnt + 6'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_FILL;
        else       state <= state_next;
    end

`ifdef MD5_HEXOUT_EN
    logic [5:0] hex_cnt;
    logic [3:0] hex_nib;
    logic [7:0] hex_char;

    // Standard MD5 text order is digest byte 0 first, high nibble before low nibble.
    always_comb begin
        hex_nib  = digest_r[{hex_cnt[4:1], ~hex_cnt[0], 2'b00} +: 4];
        hex_char = (hex_nib < 4'd10) ? (8'h30 + {4'h0, hex_nib}) : (8'h57 + {4'h0, hex_nib});
    end

    assign bus.hex_wren = (state == ST_HEX);
    assign bus.hex_data = (state != ST_HEX) ? 8'h00 : ((hex_cnt == 6'd32) ? 8'h0D : hex_char);
`else
    assign bus.hex_wren = 1'b0;
    assign bus.hex_data = 8'h00;
`endif

    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        accept       = 1'b0;
        core_start   = 1'b0;
        digest_valid = 1'b0;
        case (state)
            ST_FILL: begin
                in_ready = 1'b1;
                accept   = bus.in_valid;
                if (accept && (bus.in_last || byte_cnt == 6'd63)) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                core_start = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.core_done) begin
                    if (fin)           state_next = ST_FINAL;
                    else if (pad_pend) state_next = ST_PADBLK;
                    else               state_next = ST_FILL;
                end
            end
            ST_PADBLK: state_next = ST_ISSUE;
            ST_FINAL: begin
                digest_valid = 1'b1;
`ifdef MD5_HEXOUT_EN
                state_next = ST_HEX;
`else
                state_next = ST_FILL;
`endif
            end
`ifdef MD5_HEXOUT_EN
            ST_HEX: if (hex_cnt == 6'd32) state_next = ST_FILL;
`endif
            default: state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= 6'd0;
            msg_len  <= 61'd0;
            cha      <= IV_A;
            chb      <= IV_B;
            chc      <= IV_C;
            chd      <= IV_D;
            block    <= 512'd0;
            digest_r <= 128'd0;
            fin      <= 1'b0;
            pad_pend <= 1'b0;
            pad80    <= 1'b0;
`ifdef MD5_HEXOUT_EN
            hex_cnt  <= 6'd0;
`endif
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        block[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
                        byte_cnt <= byte_cnt + 6'd1;
                        msg_len  <= msg_len + 61'd1;
                        if (bus.in_last) begin
                            if (byte_cnt != 6'd63) block[{slot_nxt, 3'b000} +: 8] <= 8'h80;
                            // Length fits only if it does not collide with the 0x80 marker.
                            if (byte_cnt <= 6'd54) begin
                                block[511:448] <= {msg_len + 61'd1, 3'b000};
                                fin <= 1'b1;
                            end else begin
                                pad_pend <= 1'b1;
                                pad80    <= (byte_cnt == 6'd63);
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.core_done) begin
                        cha <= cha + bus.core_ra;
                        chb <= chb + bus.core_rb;
                        chc <= chc + bus.core_rc;
                        chd <= chd + bus.core_rd;
                        if (fin) begin
                            digest_r <= {chd + bus.core_rd, chc + bus.core_rc,
                                         chb + bus.core_rb, cha + bus.core_ra};
                        end else if (!pad_pend) begin
                            block    <= 512'd0;
                            byte_cnt <= 6'd0;
                        end
                    end
                end
                ST_PADBLK: begin
                    block    <= {{msg_len, 3'b000}, 440'd0, (pad80 ? 8'h80 : 8'h00)};
                    fin      <= 1'b1;
                    pad_pend <= 1'b0;
                end
                ST_FINAL: begin
                    cha      <= IV_A;
                    chb      <= IV_B;
                    chc      <= IV_C;
                    chd      <= IV_D;
                    msg_len  <= 61'd0;
                    byte_cnt <= 6'd0;
                    block    <= 512'd0;
                    fin      <= 1'b0;
                    pad80    <= 1'b0;
`ifdef MD5_HEXOUT_EN
                    hex_cnt  <= 6'd0;
`endif
                end
`ifdef MD5_HEXOUT_EN
                ST_HEX: hex_cnt <= hex_cnt + 6'd1;
`endif
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.core_start   = core_start;
    assign bus.core_block   = block;
    assign bus.core_a       = cha;
    assign bus.core_b       = chb;
    assign bus.core_c       = chc;
    assign bus.core_d       = chd;
    assign bus.digest       = digest_r;
    assign bus.digest_valid = digest_valid;
    assign state_dbg        = state;
endmodule

// File: tb/tb_md5_msg_sched.sv
// Bench for md5_msg_sched: emulates the compression core, models padding/chaining from message bytes.
// Hex-stream checks are active when MD5_HEXOUT_EN is defined.
module tb_md5_msg_sched;
    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hEFCDAB89;
    localparam logic [31:0] IV_C = 32'h98BADCFE;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [31:0] MD5_K [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    localparam int MD5_S [0:15] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    localparam logic [127:0] DIG_ABC = 128'h727fe1287d3f96d6b04fd23c98500190;
    localparam logic [127:0] DIG_A   = 128'h61267769e299c331a8b6f1c0b975c10c;

    logic       clk;
    logic       reset;
    logic [2:0] state_dbg;
    md5_msg_sched_if bus();

    md5_msg_sched dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .state_dbg (state_dbg)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_done_cyc = -10;
    bit emu_en   = 1'b1;
    bit done_req = 1'b0;

    logic [7:0]   msg[$];
    logic [511:0] exp_blk_q[$];
    logic [127:0] exp_chain_q[$];
    logic [127:0] exp_dig_q[$];
    logic [511:0] cap_blk[$];
    logic [7:0]   hex_q[$];
    logic [127:0] last_dig;
    logic [127:0] last_exp_dig;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Raw 64-round MD5 compression (no feed-forward add), as the core returns it.
    function automatic logic [127:0] md5_rounds(input logic [511:0] blk, input logic [31:0] a0,
                                                input logic [31:0] b0, input logic [31:0] c0,
                                                input logic [31:0] d0);
        logic [31:0] a, b, c, d, f;
        int g;
        a = a0; b = b0; c = c0; d = d0;
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i;               end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            f = f + a + MD5_K[i] + blk[32 * g +: 32];
            a = d; d = c; c = b;
            b = b + rotl(f, MD5_S[(i / 16) * 4 + (i % 4)]);
        end
        return {d, c, b, a};
    endfunction

    // Scoreboard model: pad the whole message, split into blocks, chain from IV.
    task automatic expect_msg(input bit want_digest);
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        logic [127:0] r;
        logic [31:0]  a, b, c, d;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 0; i < 8; i++) p.push_back(bits[8 * i +: 8]);
        a = IV_A; b = IV_B; c = IV_C; d = IV_D;
        for (int k = 0; k < p.size() / 64; k++) begin
            for (int j = 0; j < 64; j++) blk[8 * j +: 8] = p[64 * k + j];
            exp_blk_q.push_back(blk);
            exp_chain_q.push_back({d, c, b, a});
            r = md5_rounds(blk, a, b, c, d);
            a = a + r[31:0]; b = b + r[63:32]; c = c + r[95:64]; d = d + r[127:96];
        end
        if (want_digest) exp_dig_q.push_back({d, c, b, a});
    endtask

    task automatic fill_rep(input logic [7:0] v, input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] d, input logic l);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            checks++; failures++;
            $display("FAIL in_ready_timeout act=0 exp=1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_msg();
        cap_blk.delete();
        hex_q.delete();
        for (int i = 0; i < msg.size(); i++) send_byte(msg[i], (i == msg.size() - 1));
    endtask

    task automatic wait_digest();
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (n < 3000 && !seen) begin
            @(negedge clk);
            n++;
            if (bus.digest_valid) seen = 1'b1;
            else chk("in_ready_busy", 512'(bus.in_ready), 512'd0);
        end
        chk("digest_seen", 512'(seen), 512'd1);
`ifdef MD5_HEXOUT_EN
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hex_then_ready", 512'(bus.in_ready), 512'd1);
        chk("hex_count", 512'(hex_q.size()), 512'd33);
        if (hex_q.size() == 33) begin
            for (int k = 0; k < 32; k++) begin
                logic [3:0] nb;
                nb = last_exp_dig[8 * (k / 2) + ((k % 2 == 1) ? 0 : 4) +: 4];
                chk("hex_char", 512'(hex_q[k]), 512'((nb < 4'd10) ? (8'h30 + 8'(nb)) : (8'h57 + 8'(nb))));
            end
            chk("hex_cr", 512'(hex_q[32]), 512'h0D);
        end
`else
        @(negedge clk);
        chk("ready_after_final", 512'(bus.in_ready), 512'd1);
`endif
    endtask

    // ---------------- core emulator ----------------
    initial begin
        logic [127:0] r;
        int lat;
        bus.core_done = 1'b0;
        bus.core_ra = '0; bus.core_rb = '0; bus.core_rc = '0; bus.core_rd = '0;
        forever begin
            @(negedge clk);
            if (bus.core_start && emu_en) begin
                r = md5_rounds(bus.core_block, bus.core_a, bus.core_b, bus.core_c, bus.core_d);
                lat = $urandom_range(1, 6);
                repeat (lat) @(posedge clk);
                #1;
                bus.core_done = 1'b1;
                {bus.core_rd, bus.core_rc, bus.core_rb, bus.core_ra} = r;
                @(posedge clk);
                #1;
                bus.core_done = 1'b0;
            end else if (done_req) begin
                done_req = 1'b0;
                @(posedge clk);
                #1;
                bus.core_done = 1'b1;
                {bus.core_rd, bus.core_rc, bus.core_rb, bus.core_ra} = {4{32'hDEADBEEF}};
                @(posedge clk);
                #1;
                bus.core_done = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.core_done) last_done_cyc = cyc;
            if (bus.core_start) begin
                cap_blk.push_back(bus.core_block);
                if (exp_blk_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_core_start act=1 exp=0");
                end else begin
                    chk("core_block", bus.core_block, exp_blk_q.pop_front());
                    chk("core_chain", 512'({bus.core_d, bus.core_c, bus.core_b, bus.core_a}),
                        512'(exp_chain_q.pop_front()));
                end
            end
            if (bus.digest_valid) begin
                last_dig = bus.digest;
                if (exp_dig_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_digest_valid act=1 exp=0");
                end else begin
                    last_exp_dig = exp_dig_q.pop_front();
                    chk("digest", 512'(bus.digest), 512'(last_exp_dig));
                    chk("digest_latency", 512'(cyc), 512'(last_done_cyc + 1));
                end
            end
`ifdef MD5_HEXOUT_EN
            if (bus.hex_wren) hex_q.push_back(bus.hex_data);
`else
            chk("hex_idle", 512'({bus.hex_wren, bus.hex_data}), 512'd0);
`endif
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", 512'(bus.in_ready), 512'd1);
        chk("rst_core_start", 512'(bus.core_start), 512'd0);
        chk("rst_digest_valid", 512'(bus.digest_valid), 512'd0);
        chk("rst_digest", 512'(bus.digest), 512'd0);
        chk("rst_core_block", bus.core_block, 512'd0);
        chk("rst_chain", 512'({bus.core_d, bus.core_c, bus.core_b, bus.core_a}),
            512'({IV_D, IV_C, IV_B, IV_A}));
        @(posedge clk);
        #1;

        // "abc"
        msg = '{8'h61, 8'h62, 8'h63};
        expect_msg(1'b1);
        send_msg();
        wait_digest();
        chk("abc_starts", 512'(cap_blk.size()), 512'd1);
        if (cap_blk.size() == 1) begin
            chk("abc_word0", 512'(cap_blk[0][31:0]), 512'h80636261);
            chk("abc_len", 512'(cap_blk[0][511:448]), 512'd24);
        end
        chk("abc_digest_literal", 512'(last_dig), 512'(DIG_ABC));
`ifdef MD5_HEXOUT_EN
        if (hex_q.size() == 33) begin
            chk("abc_hex_first", 512'(hex_q[0]), 512'h39);
            chk("abc_hex_32nd", 512'(hex_q[31]), 512'h32);
            chk("abc_hex_last", 512'(hex_q[32]), 512'h0D);
        end
`endif
        @(posedge clk);
        #1;

        // "a"
        msg = '{8'h61};
        expect_msg(1'b1);
        send_msg();
        wait_digest();
        chk("a_digest_literal", 512'(last_dig), 512'(DIG_A));
        @(posedge clk);
        #1;

        // 55 x 'a': single block, marker at slot 55
        fill_rep(8'h61, 55);
        expect_msg(1'b1);
        send_msg();
        wait_digest();
        chk("a55_starts", 512'(cap_blk.size()), 512'd1);
        if (cap_blk.size() >= 1) begin
            chk("a55_slot54", 512'(cap_blk[0][439:432]), 512'h61);
            chk("a55_slot55", 512'(cap_blk[0][447:440]), 512'h80);
            chk("a55_len", 512'(cap_blk[0][511:448]), 512'd440);
        end
        @(posedge clk);
        #1;

        // 56 x 'a': length spills into a zero pad block
        fill_rep(8'h61, 56);
        expect_msg(1'b1);
        send_msg();
        wait_digest();
        chk("a56_starts", 512'(cap_blk.size()), 512'd2);
        if (cap_blk.size() == 2) begin
            chk("a56_blk0_slot56", 512'(cap_blk[0][455:448]), 512'h80);
            chk("a56_blk1", cap_blk[1], {64'd448, 448'd0});
        end
        @(posedge clk);
        #1;

        // 64 x 'a': marker moves to byte 0 of the pad block
        fill_rep(8'h61, 64);
        expect_msg(1'b1);
        send_msg();
        wait_digest();
        chk("a64_starts", 512'(cap_blk.size()), 512'd2);
        if (cap_blk.size() == 2) begin
            chk("a64_blk0", cap_blk[0], {64{8'h61}});
            chk("a64_blk1", cap_blk[1], {64'd512, 440'd0, 8'h80});
        end
        @(posedge clk);
        #1;

        // 130-byte pattern spanning three blocks
        msg.delete();
        for (int i = 0; i < 130; i++) msg.push_back(8'((i * 7 + 3) % 256));
        expect_msg(1'b1);
        send_msg();
        wait_digest();
        chk("p130_starts", 512'(cap_blk.size()), 512'd3);
        @(posedge clk);
        #1;

        // Reset while the core is busy; a late core_done must be ignored
        emu_en = 1'b0;
        msg = '{8'h61, 8'h62, 8'h63};
        expect_msg(1'b0);
        send_msg();
        n = 0;
        while (cap_blk.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rstwait_started", 512'(cap_blk.size()), 512'd1);
        repeat (3) @(negedge clk);
        chk("rstwait_busy", 512'(bus.in_ready), 512'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        done_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("rstwait_ready", 512'(bus.in_ready), 512'd1);
        chk("rstwait_digest", 512'(bus.digest), 512'd0);
        chk("rstwait_block", bus.core_block, 512'd0);
        chk("rstwait_chain", 512'({bus.core_d, bus.core_c, bus.core_b, bus.core_a}),
            512'({IV_D, IV_C, IV_B, IV_A}));
        emu_en = 1'b1;
        @(posedge clk);
        #1;
        expect_msg(1'b1);
        send_msg();
        wait_digest();
        chk("rst_abc_digest_literal", 512'(last_dig), 512'(DIG_ABC));

        repeat (5) @(negedge clk);
        chk("queues_drained", 512'(exp_blk_q.size() + exp_dig_q.size()), 512'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
